mux_nch_rr: RTL

- Parametrised N-channel, W-bit multiplexer with valid/ready handshakes, a registered output stage and two selection modes.
- Mode 0: external forced select.
- Mode 1: round-robin arbitration.
- Successor to the fixed 2:1/4:1 combinational muxes. Merges several producer streams onto one consumer stream in the datapath.

---
 rtl/mux_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/mux_nch_rr.sv | 112 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N-channel round-robin multiplexer and its arbiter.
package mux_pkg;

  // Selection mode encoding
  localparam logic MODE_FORCED = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Width of a channel-index field for the given channel count (at least 1 bit).
  function automatic int unsigned calc_sel_w(input int unsigned channels);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < channels) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward from last_grant+1 with wrap-around. Grant is one-hot or zero.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = calc_sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last_grant,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant
);

  localparam int NCh = int'(CHANNELS);

  int   tgt;
  logic found;

  // Walk the offsets 1..N from last_grant; first requester seen wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    tgt   = 0;
    for (int off = 1; off <= NCh; off++) begin
      tgt = int'(last_grant) + off;
      if (tgt >= NCh) begin
        tgt = tgt - NCh;
      end
      for (int i = 0; i < NCh; i++) begin
        if (enable && !found && (i == tgt) && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_nch_rr.sv
// N-channel W-bit multiplexer with valid/ready handshakes, forced-select or
// round-robin channel choice, and a single registered output stage.
module mux_nch_rr
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = calc_sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  localparam int NCh = int'(CHANNELS);

  logic [CHANNELS-1:0] grant_rr;
  logic [CHANNELS-1:0] grant_forced;
  logic [CHANNELS-1:0] grant;
  logic                load;
  logic                fire;
  logic [WIDTH-1:0]    data_sel;
  logic [SEL_W-1:0]    chan_sel;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .enable     (mode == MODE_RR),
    .grant      (grant_rr)
  );

  // Forced select: an out-of-range select matches no channel, so no grant.
  always_comb begin
    grant_forced = '0;
    for (int i = 0; i < NCh; i++) begin
      grant_forced[i] = (mode == MODE_FORCED) && (int'(select) == i) && in_valid[i];
    end
  end

  // Grant mux, load enable and ready; ready never looks at in_data.
  always_comb begin
    grant    = (mode == MODE_RR) ? grant_rr : grant_forced;
    load     = !out_valid_q || out_ready;
    in_ready = (load && !reset) ? grant : '0;
    fire     = |(in_valid & in_ready);
  end

  // One-hot AND-OR selection of data and channel index.
  always_comb begin
    data_sel = '0;
    chan_sel = '0;
    for (int i = 0; i < NCh; i++) begin
      data_sel = data_sel | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      chan_sel = chan_sel | (SEL_W'(i) & {SEL_W{grant[i]}});
    end
  end

  // Output stage next state: hold under backpressure, load or drain otherwise.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = fire;
      if (fire) begin
        out_data_d = data_sel;
        out_chan_d = chan_sel;
        // Forced transfers leave the round-robin pointer alone.
        if (mode == MODE_RR) begin
          last_grant_d = chan_sel;
        end
      end
    end
  end

  // State registers with synchronous reset; last_grant resets so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      last_grant_q <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule
